// File: rtl/score_pkg.sv
// Shared definitions for the score display: 3x5 digit font, glyph geometry,
// converter state encoding and the double-dabble step used by the converter.
package score_pkg;

  localparam int GLYPH_W    = 3;
  localparam int GLYPH_H    = 5;
  localparam int CELL_PITCH = 4;
  localparam int BCD_NIBS   = 7;  // enough decimal digits for a 20-bit value
  localparam int BCD_W      = 4 * BCD_NIBS;

  typedef logic [1:0] cvt_state_t;
  localparam cvt_state_t ST_IDLE   = 2'd0;
  localparam cvt_state_t ST_SHIFT  = 2'd1;
  localparam cvt_state_t ST_COMMIT = 2'd2;

  // Row 0 occupies bits [14:12]; within a row the MSB is column 0.
  localparam logic [14:0] FONT [10] = '{
    15'b111_101_101_101_111,  // 0
    15'b110_010_010_010_010,  // 1
    15'b111_001_111_100_111,  // 2
    15'b111_001_111_001_111,  // 3
    15'b101_101_111_001_001,  // 4
    15'b111_100_111_001_111,  // 5
    15'b111_100_111_101_111,  // 6
    15'b111_001_001_001_001,  // 7
    15'b111_101_111_101_111,  // 8
    15'b111_101_111_001_111   // 9
  };

  // One shift-and-add-3 step: correct every nibble >= 5, then shift in_bit in.
  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] bcd,
                                               input logic in_bit);
    logic [BCD_W-1:0] adj;
    for (int i = 0; i < BCD_NIBS; i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    return BCD_W'({adj, in_bit});
  endfunction

endpackage

// File: rtl/digit_glyph.sv
// Render stage 2: font lookup of a registered digit/cell, registered lit output.
// Latency 1 cycle; digit codes above 9 and cells outside 3x5 render dark.
// No backpressure: one pixel per cycle.
module digit_glyph
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic [1:0] col,
  input  logic [2:0] row,
  output logic       lit
);

  logic        lit_d, lit_q;
  logic [14:0] glyph;
  logic [3:0]  bit_idx;

  always_comb begin
    glyph = '0;
    if (digit <= 4'd9) glyph = FONT[digit];
    bit_idx = 4'd14 - (4'(row) * 4'(GLYPH_W) + 4'(col));
    lit_d = 1'b0;
    if (int'(col) < GLYPH_W && int'(row) < GLYPH_H) lit_d = glyph[bit_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lit_q <= 1'b0;
    else        lit_q <= lit_d;
  end

  assign lit = lit_q;

endmodule

// File: rtl/score_display.sv
// Binary score -> BCD (double dabble) -> scaled 3x5 glyph pixels; LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: digits visible VALUE_W+2 cycles after the accepting edge; pix lags hpos/vpos by 2 cycles.
// Backpressure: value_ready low while converting; loads offered while busy are dropped.
module score_display
  import score_pkg::*;
#(
  parameter int DIGITS     = 2,
  parameter int VALUE_W    = 7,
  parameter int SCALE_LOG2 = 2,
  parameter int X0         = 0,
  parameter int Y0         = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  output logic               value_ready,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  output logic               pix
);

  localparam int          DW       = 4 * DIGITS;
  localparam logic [4:0]  CNT_LAST = 5'(VALUE_W);
  localparam logic [10:0] X0_L     = 11'(X0);
  localparam logic [10:0] Y0_L     = 11'(Y0);
  localparam logic [10:0] BOX_W    = 11'((CELL_PITCH * DIGITS - 1) << SCALE_LOG2);
  localparam logic [10:0] BOX_H    = 11'(GLYPH_H << SCALE_LOG2);

  cvt_state_t         state_d, state_q;
  logic [4:0]         cnt_d, cnt_q;
  logic [VALUE_W-1:0] bin_d, bin_q;
  logic [BCD_W-1:0]   bcd_d, bcd_q;
  logic [DW-1:0]      disp_d, disp_q;

  logic [3:0]  dig_d, dig_q;
  logic [1:0]  col_d, col_q;
  logic [2:0]  row_d, row_q;

  logic [10:0] dx, dy, cx, cy;
  logic [2:0]  k;
  logic [1:0]  gc;
  logic        in_box, blank;
  logic [DW-1:0] upper;

  assign value_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    disp_d  = disp_q;
    case (state_q)
      ST_IDLE: begin
        if (value_valid) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bin_d   = value;
          bcd_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_COMMIT;
        end else begin
          bcd_d = dabble(bcd_q, bin_q[VALUE_W-1]);
          bin_d = bin_q << 1;
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_COMMIT: begin
        // Anything in the nibbles above the shown digits means overflow: pin to all nines.
        state_d = ST_IDLE;
        disp_d  = (|bcd_q[BCD_W-1:DW]) ? {DIGITS{4'd9}} : bcd_q[DW-1:0];
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dx     = {1'b0, hpos} - X0_L;
    dy     = {1'b0, vpos} - Y0_L;
    in_box = ({1'b0, hpos} >= X0_L) && (dx < BOX_W) &&
             ({1'b0, vpos} >= Y0_L) && (dy < BOX_H);
    cx     = dx >> SCALE_LOG2;
    cy     = dy >> SCALE_LOG2;
    k      = 3'(cx >> $clog2(CELL_PITCH));
    gc     = 2'(cx);
    // Digit k plus every more significant digit, right-aligned.
    upper  = disp_q >> (4 * (DIGITS - 1 - int'(k)));
`ifdef LEADING_ZERO_BLANK_EN
    blank  = (int'(k) < DIGITS - 1) && (upper == '0);
`else
    blank  = 1'b0;
`endif
    dig_d  = (in_box && int'(gc) < GLYPH_W && !blank) ? 4'(upper) : 4'hF;
    col_d  = gc;
    row_d  = 3'(cy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      disp_q  <= '0;
      dig_q   <= 4'hF;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      disp_q  <= disp_d;
      dig_q   <= dig_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  digit_glyph u_glyph (
    .clk   (clk),
    .rst_n (rst_n),
    .digit (dig_q),
    .col   (col_q),
    .row   (row_q),
    .lit   (pix)
  );

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: two instances (scale 1 and scale 4) share stimulus;
// expected pix/ready values are queued with a due cycle and checked by a negedge monitor.
module tb_score_display;

  localparam int X0A = 8,  Y0A = 4;
  localparam int X0B = 40, Y0B = 20;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [14:0] TB_FONT [10] = '{
    15'b111_101_101_101_111, 15'b110_010_010_010_010, 15'b111_001_111_100_111,
    15'b111_001_111_001_111, 15'b101_101_111_001_001, 15'b111_100_111_001_111,
    15'b111_100_111_101_111, 15'b111_001_001_001_001, 15'b111_101_111_101_111,
    15'b111_101_111_001_111
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] value;
  logic       value_valid;
  logic       rdy_a, rdy_b, pix_a, pix_b;
  logic [9:0] hpos, vpos;

  always #5 clk = ~clk;

  score_display #(.DIGITS(2), .VALUE_W(7), .SCALE_LOG2(0), .X0(X0A), .Y0(Y0A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
    .value_ready(rdy_a), .hpos(hpos), .vpos(vpos), .pix(pix_a)
  );

  score_display #(.DIGITS(2), .VALUE_W(7), .SCALE_LOG2(2), .X0(X0B), .Y0(Y0B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
    .value_ready(rdy_b), .hpos(hpos), .vpos(vpos), .pix(pix_b)
  );

  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    sb_due[$];
  int    sb_kind[$];   // 0 pix_a, 1 pix_b, 2 rdy_a, 3 rdy_b
  logic  sb_exp[$];
  string sb_name[$];
  logic  mon_act;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = sb_due.size() - 1; i >= 0; i--) begin
      if (sb_due[i] <= cyc) begin
        case (sb_kind[i])
          0:       mon_act = pix_a;
          1:       mon_act = pix_b;
          2:       mon_act = rdy_a;
          default: mon_act = rdy_b;
        endcase
        n_cmp++;
        if (mon_act !== sb_exp[i]) begin
          n_bad++;
          $display("FAIL %s (kind %0d): got %0b, expected %0b at cycle %0d",
                   sb_name[i], sb_kind[i], mon_act, sb_exp[i], cyc);
        end
        sb_due.delete(i);
        sb_kind.delete(i);
        sb_exp.delete(i);
        sb_name.delete(i);
      end
    end
  end

  function automatic logic model_pix(int s, int x0, int y0, int h, int v, logic [7:0] d);
    int cx, cy, k, c;
    logic [3:0]  dig;
    logic [14:0] g;
    if (h < x0 || v < y0) return 1'b0;
    cx = (h - x0) >> s;
    cy = (v - y0) >> s;
    if (cx >= 7 || cy >= 5) return 1'b0;
    k = cx / 4;
    c = cx % 4;
    if (c == 3) return 1'b0;
    dig = (k == 0) ? d[7:4] : d[3:0];
    if (BLANK && k == 0 && dig == 4'd0) return 1'b0;
    g = TB_FONT[dig];
    return g[14 - (cy * 3 + c)];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int lat, input int kind, input logic e, input string nm);
    sb_due.push_back(cyc + lat);
    sb_kind.push_back(kind);
    sb_exp.push_back(e);
    sb_name.push_back(nm);
  endtask

  task automatic drive_pix(input int h, input int v, input logic [7:0] d, input string nm);
    hpos = 10'(h);
    vpos = 10'(v);
    expect_at(2, 0, model_pix(0, X0A, Y0A, h, v, d), nm);
    expect_at(2, 1, model_pix(2, X0B, Y0B, h, v, d), nm);
  endtask

  task automatic scan(input int xl, input int xh, input int yl, input int yh,
                      input logic [7:0] d, input string nm);
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        drive_pix(x, y, d, nm);
        step();
      end
    end
    step();
    step();
  endtask

  task automatic spot(input int kind, input int h, input int v, input logic e, input string nm);
    hpos = 10'(h);
    vpos = 10'(v);
    expect_at(2, kind, e, nm);
    step();
  endtask

  task automatic load(input logic [6:0] v);
    value       = v;
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      expect_at(0, 2, 1'b0, "busy_rdy");
      step();
    end
    expect_at(0, 2, 1'b1, "done_rdy_a");
    expect_at(0, 3, 1'b1, "done_rdy_b");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; value = '0; value_valid = 1'b0;
    hpos = 10'(X0A + 4); vpos = 10'(Y0A + 1);
    step();
    expect_at(0, 2, 1'b1, "rst_rdy_a");
    expect_at(0, 3, 1'b1, "rst_rdy_b");
    expect_at(2, 0, 1'b0, "rst_pix_a");
    expect_at(2, 1, 1'b0, "rst_pix_b");
    hpos = 10'(X0B); vpos = 10'(Y0B);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    step();

    scan(X0A - 1, X0A + 7, Y0A - 1, Y0A + 5, 8'h00, "scan_00");

    // 42: ready low 9 cycles, in-flight pixel keeps old digits, next one sees new.
    value = 7'd42; value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      expect_at(0, 2, 1'b0, "busy42_rdy");
      if (i == 8) drive_pix(X0A + 4, Y0A + 1, 8'h00, "inflight_old");
      step();
    end
    expect_at(0, 2, 1'b1, "idle42_rdy");
    drive_pix(X0A + 4, Y0A + 1, 8'h42, "commit_new");
    step();
    spot(0, X0A + 4, Y0A, 1'b1, "lit_x4_y0");
    spot(0, X0A + 3, Y0A, 1'b0, "gap_x3_y0");
    spot(0, X0A + 1, Y0A, 1'b0, "four_open_top");
    spot(0, X0A,     Y0A, 1'b1, "four_top_left");
    step();
    scan(X0A - 1, X0A + 7, Y0A - 1, Y0A + 5, 8'h42, "scan_42");

    // Valid held through a conversion while value changes 13 -> 77.
    value = 7'd13; value_valid = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      if (i == 2) value = 7'd77;
      expect_at(0, 3, 1'b0, "busy13_rdy");
      step();
    end
    value_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_at(0, 2, 1'b1, "no_requeue_rdy");
      step();
    end
    scan(X0A - 1, X0A + 7, Y0A - 1, Y0A + 5, 8'h13, "scan_13");

    load(7'd127);
    scan(X0A - 1, X0A + 7, Y0A - 1, Y0A + 5, 8'h99, "scan_sat99");
    load(7'd5);
    scan(X0A - 1, X0A + 7, Y0A - 1, Y0A + 5, 8'h05, "scan_05");

    // Reset in the middle of converting 63.
    hpos = 10'(X0A + 4); vpos = 10'(Y0A + 1);
    value = 7'd63; value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    expect_at(0, 2, 1'b1, "abort_rdy_a");
    expect_at(0, 3, 1'b1, "abort_rdy_b");
    expect_at(1, 0, 1'b0, "abort_pix_a");
    step();
    step();
    rst_n = 1'b1;
    expect_at(0, 2, 1'b1, "post_rst_rdy");
    step();
    step();
    scan(X0A - 1, X0A + 7, Y0A - 1, Y0A + 5, 8'h00, "scan_abort_00");
    load(7'd21);
    scan(X0A - 1, X0A + 7, Y0A - 1, Y0A + 5, 8'h21, "scan_21");

    // Scale-4 instance: each glyph cell is a 4x4 block.
    load(7'd8);
    spot(1, X0B + 20, Y0B,      1'b1, "b_eight_top_mid");
    spot(1, X0B + 23, Y0B + 7,  1'b0, "b_eight_hole");
    spot(1, X0B + 12, Y0B,      1'b0, "b_gap");
    spot(1, X0B + 27, Y0B + 19, 1'b1, "b_eight_bot_right");
    spot(1, X0B + 28, Y0B,      1'b0, "b_right_of_box");
    spot(1, X0B,      Y0B,      !BLANK, "b_tens_zero");
    step();
    scan(X0B - 1, X0B + 28, Y0B - 1, Y0B + 20, 8'h08, "scan_b_08");

    repeat (3) step();
    if (sb_due.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d checks left, expected 0", sb_due.size());
      n_cmp += sb_due.size();
      n_bad += sb_due.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter DIGITS, default 2: number of decimal digits rendered, 1..6.
REQ-002 Parameter VALUE_W, default 7: width of binary input value, 1..20.
REQ-003 Parameter SCALE_LOG2, default 2: glyph pixel magnification is 2^SCALE_LOG2, 0..4.
REQ-004 Parameter X0, default 0; Parameter Y0, default 0: screen position of the top-left pixel of the display box.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 value  input  VALUE_W  binary score to show.
REQ-008 value_valid  input  1  load request for value.
REQ-009 value_ready  output  1  high when the converter accepts a load.
REQ-010 hpos  input  10  current beam column.
REQ-011 vpos  input  10  current beam row.
REQ-012 pix  output  1  high when the beam pixel belongs to a lit glyph segment.

Function
REQ-013 A load is accepted only on a cycle with value_valid=1 and value_ready=1; value is captured that cycle.
REQ-014 The converter FSM SHALL have states IDLE, SHIFT and COMMIT; value_ready=1 only in IDLE.
REQ-015 IDLE->SHIFT on an accepted load; SHIFT runs exactly VALUE_W cycles of shift-and-add-3 (add 3 to every BCD nibble >=5 before each left shift); SHIFT->COMMIT after the last shift; COMMIT->IDLE after one cycle.
REQ-016 Load-to-display latency: the new digits become visible VALUE_W+2 cycles after the accepting edge.
REQ-017 Displayed BCD register updates only in COMMIT, all digits at once; no partial values reach the renderer.
REQ-018 If the converted value exceeds 10^DIGITS-1, every displayed digit SHALL be 9 (saturation).
REQ-019 value_valid while busy is ignored and not queued.
REQ-020 Box width (4*DIGITS-1)*2^SCALE_LOG2, height 5*2^SCALE_LOG2; digit k (k=0 leftmost, most significant) occupies columns X0+4k*2^SCALE_LOG2 .. +3*2^SCALE_LOG2-1; the fourth glyph column is a blank gap.
REQ-021 Glyph cell = (column offset >> SCALE_LOG2, row offset >> SCALE_LOG2); 3x5 font, row 0 top, column 0 left.
REQ-022 Font: standard 3x5 seven-segment-style shapes for 0..9; 1 drawn as a centre vertical stroke with an upper-left serif; 4 has an open top.
REQ-023 pix = 0 outside the box, in gap columns, and for unlit cells.
REQ-024 Render pipeline has 2 register stages: pix reflects hpos/vpos sampled 2 edges earlier.
REQ-025 A COMMIT coinciding with rendering takes effect for pixels sampled after that edge; earlier in-flight pixels keep the old digits.

Reset
REQ-026 During rst_n=0: FSM IDLE, value_ready=1, displayed BCD all zero, pipeline registers cleared, pix=0.
REQ-027 Reset asserted mid-SHIFT abandons the conversion; after release the display shows 0 until a new load commits.

Configuration
REQ-028 With LEADING_ZERO_BLANK_EN defined, digits more significant than the highest non-zero digit render blank, and the least significant digit is always drawn.
REQ-029 Without LEADING_ZERO_BLANK_EN, all DIGITS digits are drawn, including leading zeros.

Structure
REQ-030 Shared package score_pkg holds the font table constant (10 x 15 bits), GLYPH_W=3, GLYPH_H=5, CELL_PITCH=4 and the FSM state typedef.
REQ-031 One sub-module, digit_glyph: registered 4-bit digit + 2-bit column + 3-bit row -> 1-bit lit; it forms render stage 2.

Verification
REQ-032 Reset then scan box, DIGITS=2, SCALE_LOG2=0, blank off -> pattern "00"; blank on -> " 0".
REQ-033 Load value=42 (VALUE_W=7) -> value_ready low 9 cycles; digits become 4,2 on edge 9; pixel (X0+4,Y0+0) lit, (X0+3,Y0+0) unlit (gap).
REQ-034 Load 127 with DIGITS=2 -> display "99"; load 5 with blank on -> " 5".
REQ-035 value_valid held high through a conversion with value changing 13->77 -> only 13 displayed, 77 not captured.
REQ-036 SCALE_LOG2=2, value 8 -> every glyph cell is a 4x4 pixel block; pix lags hpos by exactly 2 cycles.
REQ-037 rst_n pulsed low mid-SHIFT of 63 -> display 0, value_ready=1 immediately; next load 21 shows "21".
